// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Turn scheduler for the tic-tac-toe design. Owns the 18-bit game board,
// alternates moves between the UART user front end (user plays O) and the
// computer move generator (FPGA plays X), validates every move, detects a win
// or a draw, strobes the result to the user front end, waits for the result
// print to finish, then clears the board and starts the next game.
//
// Board encoding: square 1 = bits[17:16] ... square 9 = bits[1:0].
// Square values: 00 empty, 01 O (user), 10 X (FPGA).
//
// Parameters
//   USER_FIRST       first game starts with the user (1) or the FPGA (0)
//   ALTERNATE_FIRST  when 1 the first mover toggles after every finished game
//   AI_TIMEOUT       clocks to wait for an AI move before the fallback move
//
// Ports
//   i_clk            global clock
//   i_rst_n          asynchronous active-low reset
//   o_board          current board (registered)
//   o_needinput      level: user move requested
//   i_user_busy      user front end busy printing or receiving
//   i_user_move      user square, valid with i_user_move_stb
//   i_user_move_stb  one-cycle user move strobe
//   o_ai_req         one-cycle request for an FPGA move on current o_board
//   i_ai_move        AI square, valid with i_ai_move_stb
//   i_ai_move_stb    one-cycle AI move strobe
//   o_result         1 = X (FPGA) wins, 2 = O (user) wins, 0 = none
//   o_isdraw         game drawn
//   o_result_stb     one-cycle strobe; o_result/o_isdraw valid
//   o_user_turn      1 while the user is on move
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter bit          USER_FIRST      = 1'b1,
  parameter bit          ALTERNATE_FIRST = 1'b1,
  parameter logic [23:0] AI_TIMEOUT      = 24'd1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [17:0] o_board,
  output logic        o_needinput,
  input  logic        i_user_busy,
  input  logic [3:0]  i_user_move,
  input  logic        i_user_move_stb,
  output logic        o_ai_req,
  input  logic [3:0]  i_ai_move,
  input  logic        i_ai_move_stb,
  output logic [1:0]  o_result,
  output logic        o_isdraw,
  output logic        o_result_stb,
  output logic        o_user_turn
);

  typedef enum logic [3:0] {
    S_START,
    S_USER,
    S_USER_CHK,
    S_AI_REQ,
    S_AI_WAIT,
    S_EVAL,
    S_RES_HI,
    S_RES_LO,
    S_CLEAR
  } state_t;

  localparam logic [1:0] SQ_EMPTY = 2'b00;
  localparam logic [1:0] SQ_O     = 2'b01;
  localparam logic [1:0] SQ_X     = 2'b10;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_X    = 2'd1;
  localparam logic [1:0] RES_O    = 2'd2;

  // ---------------------------------------------------------------------------
  // Board helpers. Squares are numbered 1..9; anything else reads as "not a
  // square" so out-of-range moves can never alias onto a real square.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] sq_get(input logic [17:0] b, input logic [3:0] sq);
    logic [1:0] v;
    v = SQ_EMPTY;
    for (int i = 1; i <= 9; i++) begin
      if (sq == 4'(i)) v = b[2*(9-i) +: 2];
    end
    return v;
  endfunction

  function automatic logic [17:0] sq_set(input logic [17:0] b, input logic [3:0] sq,
                                         input logic [1:0] mark);
    logic [17:0] r;
    r = b;
    for (int i = 1; i <= 9; i++) begin
      if (sq == 4'(i)) r[2*(9-i) +: 2] = mark;
    end
    return r;
  endfunction

  function automatic logic sq_ok(input logic [17:0] b, input logic [3:0] sq);
    return (sq >= 4'd1) && (sq <= 4'd9) && (sq_get(b, sq) == SQ_EMPTY);
  endfunction

  // Lowest-numbered empty square; 0 when the board is full. Scanning from
  // square 9 down lets the last hit be the lowest index.
  function automatic logic [3:0] lowest_empty(input logic [17:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 9; i >= 1; i--) begin
      if (b[2*(9-i) +: 2] == SQ_EMPTY) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic line3(input logic [17:0] b, input logic [3:0] a,
                                 input logic [3:0] c, input logic [3:0] d,
                                 input logic [1:0] mark);
    return (sq_get(b, a) == mark) && (sq_get(b, c) == mark) && (sq_get(b, d) == mark);
  endfunction

  function automatic logic has_win(input logic [17:0] b, input logic [1:0] mark);
    return line3(b, 4'd1, 4'd2, 4'd3, mark) ||   // rows
           line3(b, 4'd4, 4'd5, 4'd6, mark) ||
           line3(b, 4'd7, 4'd8, 4'd9, mark) ||
           line3(b, 4'd1, 4'd4, 4'd7, mark) ||   // columns
           line3(b, 4'd2, 4'd5, 4'd8, mark) ||
           line3(b, 4'd3, 4'd6, 4'd9, mark) ||
           line3(b, 4'd1, 4'd5, 4'd9, mark) ||   // diagonals
           line3(b, 4'd3, 4'd5, 4'd7, mark);
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [17:0] board_nxt;
  logic        needinput_nxt;
  logic        ai_req_nxt;
  logic [1:0]  result_nxt;
  logic        isdraw_nxt;
  logic        result_stb_nxt;
  logic        user_turn_nxt;
  logic        first_user, first_user_nxt;   // who opened the current game
  logic [3:0]  user_move_q, user_move_nxt;
  logic [23:0] ai_cnt, ai_cnt_nxt;

  logic        x_win;
  logic        o_win;
  logic        board_full;
  logic [3:0]  fallback_sq;

  assign x_win       = has_win(o_board, SQ_X);
  assign o_win       = has_win(o_board, SQ_O);
  assign fallback_sq = lowest_empty(o_board);
  assign board_full  = (fallback_sq == 4'd0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_START;
      o_board      <= '0;
      o_needinput  <= 1'b0;
      o_ai_req     <= 1'b0;
      o_result     <= RES_NONE;
      o_isdraw     <= 1'b0;
      o_result_stb <= 1'b0;
      o_user_turn  <= USER_FIRST;
      first_user   <= USER_FIRST;
      user_move_q  <= '0;
      ai_cnt       <= '0;
    end else begin
      state        <= state_nxt;
      o_board      <= board_nxt;
      o_needinput  <= needinput_nxt;
      o_ai_req     <= ai_req_nxt;
      o_result     <= result_nxt;
      o_isdraw     <= isdraw_nxt;
      o_result_stb <= result_stb_nxt;
      o_user_turn  <= user_turn_nxt;
      first_user   <= first_user_nxt;
      user_move_q  <= user_move_nxt;
      ai_cnt       <= ai_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_nxt      = state;
    board_nxt      = o_board;
    result_nxt     = o_result;
    isdraw_nxt     = o_isdraw;
    result_stb_nxt = 1'b0;
    user_turn_nxt  = o_user_turn;
    first_user_nxt = first_user;
    user_move_nxt  = user_move_q;
    ai_cnt_nxt     = ai_cnt;

    unique case (state)
      // Hold off until the front end has finished printing instructions.
      S_START: begin
        if (!i_user_busy) state_nxt = o_user_turn ? S_USER : S_AI_REQ;
      end

      S_USER: begin
        if (i_user_move_stb) begin
          user_move_nxt = i_user_move;
          state_nxt     = S_USER_CHK;
        end
      end

      // An illegal move leaves the board alone; the front end is likely busy
      // printing a complaint, so re-prompt only once it goes idle.
      S_USER_CHK: begin
        if (sq_ok(o_board, user_move_q)) begin
          board_nxt = sq_set(o_board, user_move_q, SQ_O);
          state_nxt = S_EVAL;
        end else if (!i_user_busy) begin
          state_nxt = S_USER;
        end
      end

      S_AI_REQ: begin
        ai_cnt_nxt = '0;
        state_nxt  = S_AI_WAIT;
      end

      // A bad AI square and a silent AI both fall back to the lowest empty
      // square. The board can never be full here: a full board ends the game
      // in S_EVAL before the AI is asked.
      S_AI_WAIT: begin
        if (i_ai_move_stb) begin
          if (sq_ok(o_board, i_ai_move)) board_nxt = sq_set(o_board, i_ai_move, SQ_X);
          else                           board_nxt = sq_set(o_board, fallback_sq, SQ_X);
          state_nxt = S_EVAL;
        end else if (ai_cnt == AI_TIMEOUT - 24'd1) begin
          board_nxt = sq_set(o_board, fallback_sq, SQ_X);
          state_nxt = S_EVAL;
        end else begin
          ai_cnt_nxt = ai_cnt + 24'd1;
        end
      end

      // Wins are checked before fullness so a ninth-move win is never a draw.
      S_EVAL: begin
        if (x_win) begin
          result_nxt     = RES_X;
          result_stb_nxt = 1'b1;
          state_nxt      = S_RES_HI;
        end else if (o_win) begin
          result_nxt     = RES_O;
          result_stb_nxt = 1'b1;
          state_nxt      = S_RES_HI;
        end else if (board_full) begin
          isdraw_nxt     = 1'b1;
          result_stb_nxt = 1'b1;
          state_nxt      = S_RES_HI;
        end else begin
          user_turn_nxt = !o_user_turn;
          state_nxt     = o_user_turn ? S_AI_REQ : S_USER;
        end
      end

      // Result print handshake: busy rises, then falls.
      S_RES_HI: begin
        if (i_user_busy) state_nxt = S_RES_LO;
      end

      S_RES_LO: begin
        if (!i_user_busy) state_nxt = S_CLEAR;
      end

      S_CLEAR: begin
        board_nxt  = '0;
        result_nxt = RES_NONE;
        isdraw_nxt = 1'b0;
        if (ALTERNATE_FIRST) begin
          user_turn_nxt  = !first_user;
          first_user_nxt = !first_user;
        end else begin
          user_turn_nxt  = USER_FIRST;
          first_user_nxt = USER_FIRST;
        end
        state_nxt = S_START;
      end

      default: state_nxt = S_START;
    endcase

    // Level/pulse outputs follow the state being entered, so they are
    // registered yet line up exactly with residency in that state.
    needinput_nxt = (state_nxt == S_USER);
    ai_req_nxt    = (state_nxt == S_AI_REQ);
  end

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Self-checking bench for game_sequencer. The bench plays both the user front
// end and the AI move generator. A reference model holds the board as nine
// integers (0 empty, 1 O, 2 X), applies the game rules directly and predicts
// the board, the next prompt, and the result of every game.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] board;
  logic        needinput;
  logic        user_busy;
  logic [3:0]  user_move;
  logic        user_move_stb;
  logic        ai_req;
  logic [3:0]  ai_move;
  logic        ai_move_stb;
  logic [1:0]  result;
  logic        isdraw;
  logic        result_stb;
  logic        user_turn;

  always #5 clk = ~clk;

  game_sequencer #(
    .USER_FIRST      (1'b1),
    .ALTERNATE_FIRST (1'b1),
    .AI_TIMEOUT      (24'(TMO))
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_board         (board),
    .o_needinput     (needinput),
    .i_user_busy     (user_busy),
    .i_user_move     (user_move),
    .i_user_move_stb (user_move_stb),
    .o_ai_req        (ai_req),
    .i_ai_move       (ai_move),
    .i_ai_move_stb   (ai_move_stb),
    .o_result        (result),
    .o_isdraw        (isdraw),
    .o_result_stb    (result_stb),
    .o_user_turn     (user_turn)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int mb [1:9];
  bit m_user;
  bit m_first;
  int games_done;
  int n_err;
  int n_checks;

  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9},
                       '{1,4,7}, '{2,5,8}, '{3,6,9},
                       '{1,5,9}, '{3,5,7}};

  function automatic logic [17:0] m_enc();
    logic [17:0] r;
    r = '0;
    for (int s = 1; s <= 9; s++) r[2*(9-s) +: 2] = 2'(mb[s]);
    return r;
  endfunction

  // 1 = X wins, 2 = O wins, 0 = nobody
  function automatic int m_winner();
    for (int l = 0; l < 8; l++) begin
      if (mb[lines[l][0]] != 0 && mb[lines[l][0]] == mb[lines[l][1]] &&
          mb[lines[l][0]] == mb[lines[l][2]])
        return (mb[lines[l][0]] == 2) ? 1 : 2;
    end
    return 0;
  endfunction

  function automatic bit m_full();
    for (int s = 1; s <= 9; s++) if (mb[s] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_lowest();
    for (int s = 1; s <= 9; s++) if (mb[s] == 0) return s;
    return 0;
  endfunction

  function automatic bit m_legal(input int sq);
    if (sq < 1 || sq > 9) return 1'b0;
    return mb[sq] == 0;
  endfunction

  function automatic int m_random_empty();
    int q[$];
    for (int s = 1; s <= 9; s++) if (mb[s] == 0) q.push_back(s);
    if (q.size() == 0) return 0;
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  function automatic int m_random_illegal();
    int q[$];
    for (int s = 1; s <= 9; s++) if (mb[s] != 0) q.push_back(s);
    q.push_back(0);
    q.push_back(int'($urandom_range(10, 15)));
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic m_clear();
    for (int s = 1; s <= 9; s++) mb[s] = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Kinds: 1 = user prompted, 2 = AI requested, 3 = result strobe, 0 = none.
  task automatic wait_event(output int kind);
    kind = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (result_stb)     kind = 3;
      else if (ai_req)    kind = 2;
      else if (needinput) kind = 1;
      if (kind != 0) break;
    end
  endtask

  // Waits for what the model says comes next and checks it. A finished game
  // is run through the result handshake and the next game's opening prompt.
  task automatic expect_next(input string tag);
    int kind;
    int win;
    bit over;
    win  = m_winner();
    over = (win != 0) || m_full();
    wait_event(kind);
    check({tag, "_event"}, kind, over ? 3 : (m_user ? 1 : 2));
    check({tag, "_board"}, board, m_enc());
    if (over) begin
      check({tag, "_result"}, result, win);
      check({tag, "_isdraw"}, isdraw, (win == 0) ? 1 : 0);
      @(negedge clk);
      check({tag, "_stb_width"}, result_stb, 0);
      user_busy = 1'b1;
      repeat (3) @(negedge clk);
      check({tag, "_board_held"}, board, m_enc());
      user_busy = 1'b0;
      m_clear();
      m_first = !m_first;
      m_user  = m_first;
      games_done++;
      wait_event(kind);
      check({tag, "_next_event"}, kind, m_user ? 1 : 2);
      check({tag, "_cleared"}, board, 0);
      check({tag, "_res_cleared"}, {result, isdraw}, 0);
    end
    check({tag, "_turn"}, user_turn, m_user);
  endtask

  // Called right after the user prompt was observed.
  task automatic user_play(input string tag, input int sq, input int busy_cyc,
                           input bit stray_ai);
    user_move     = 4'(sq);
    user_move_stb = 1'b1;
    if (stray_ai) begin
      ai_move     = 4'(m_random_empty());
      ai_move_stb = 1'b1;
    end
    if (busy_cyc > 0) user_busy = 1'b1;
    @(negedge clk);
    user_move_stb = 1'b0;
    ai_move_stb   = 1'b0;
    if (busy_cyc > 0) begin
      repeat (busy_cyc) @(negedge clk);
      check({tag, "_noprompt_busy"}, {needinput, ai_req}, 0);
      user_busy = 1'b0;
    end
    if (m_legal(sq)) begin
      mb[sq] = 1;
      if (m_winner() == 0 && !m_full()) m_user = 1'b0;
    end
    expect_next(tag);
  endtask

  // Called right after o_ai_req was observed.
  task automatic ai_play(input string tag, input int sq, input int delay,
                         input bit skip, input bit stray_user);
    logic [17:0] prev;
    int          n;
    @(negedge clk);
    if (skip) begin
      prev = board;
      n    = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        n++;
        if (board !== prev) break;
      end
      // n counts from the cycle after o_ai_req; +1 includes that cycle.
      check({tag, "_timeout_lo"}, (n + 1 >= TMO) ? 1 : 0, 1);
      check({tag, "_timeout_hi"}, (n + 1 <= TMO + 1) ? 1 : 0, 1);
      mb[m_lowest()] = 2;
    end else begin
      repeat (delay) @(negedge clk);
      ai_move     = 4'(sq);
      ai_move_stb = 1'b1;
      if (stray_user) begin
        user_move     = 4'(m_random_empty());
        user_move_stb = 1'b1;
      end
      @(negedge clk);
      ai_move_stb   = 1'b0;
      user_move_stb = 1'b0;
      if (m_legal(sq)) mb[sq] = 2;
      else             mb[m_lowest()] = 2;
    end
    if (m_winner() == 0 && !m_full()) m_user = 1'b1;
    expect_next(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int guard;
    int r;
    n_err = 0; n_checks = 0; games_done = 0;
    rst_n = 1'b0;
    user_busy = 1'b0; user_move = '0; user_move_stb = 1'b0;
    ai_move = '0; ai_move_stb = 1'b0;
    m_clear();
    m_user = 1'b1; m_first = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_board", board, 0);
    check("rst_needinput", needinput, 0);
    check("rst_ai_req", ai_req, 0);
    check("rst_result", result, 0);
    check("rst_isdraw", isdraw, 0);
    check("rst_result_stb", result_stb, 0);
    check("rst_user_turn", user_turn, 1);
    rst_n = 1'b1;
    expect_next("g1_open");

    // Game 1: user wins on the top row; two illegal user moves on the way.
    user_play("g1_u1", 1, 0, 0);
    ai_play("g1_a5", 5, 0, 0, 0);
    user_play("g1_u5_occupied", 5, 3, 0);
    user_play("g1_uA_range", 10, 2, 0);
    user_play("g1_u2", 2, 0, 0);
    ai_play("g1_a9", 9, 1, 0, 0);
    user_move = 4'd3; user_move_stb = 1'b1;
    @(negedge clk);
    user_move_stb = 1'b0;
    mb[3] = 1;
    begin
      int kind;
      wait_event(kind);
      check("g1_win_event", kind, 3);
      check("g1_win_board", board, 18'b01_01_01_00_10_00_00_00_10);
      check("g1_win_result", result, 2);
      @(negedge clk);
      check("g1_win_stb_width", result_stb, 0);
      user_busy = 1'b1;
      repeat (2) @(negedge clk);
      user_busy = 1'b0;
      m_clear(); m_first = 1'b0; m_user = 1'b0; games_done++;
      wait_event(kind);
      check("g2_open_ai", kind, 2);
      check("g2_open_board", board, 0);
    end

    // Game 2: AI opens; silent AI times out, then an occupied AI square.
    ai_play("g2_a_timeout", 0, 0, 1, 0);
    user_play("g2_u5", 5, 0, 0);
    ai_play("g2_a1_occupied", 1, 0, 0, 0);
    user_play("g2_u9", 9, 0, 0);
    ai_play("g2_a3", 3, 0, 0, 0);

    // Game 3: user opens, AI wins on its third move with 3,5,7.
    user_play("g3_u1", 1, 0, 0);
    ai_play("g3_a3", 3, 0, 0, 0);
    user_play("g3_u2", 2, 0, 0);
    ai_play("g3_a5", 5, 0, 0, 1);
    user_play("g3_u4", 4, 0, 1);
    ai_play("g3_a7", 7, 2, 0, 0);

    // Game 4: AI opens; reset lands in the AI wait with four moves placed.
    ai_play("g4_a5", 5, 0, 0, 0);
    user_play("g4_u1", 1, 0, 0);
    ai_play("g4_a9", 9, 0, 0, 0);
    user_play("g4_u2", 2, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_board", board, 0);
    check("mid_rst_outputs", {needinput, ai_req, result, isdraw, result_stb}, 0);
    check("mid_rst_user_turn", user_turn, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear(); m_user = 1'b1; m_first = 1'b1;
    expect_next("g5_open");

    // Game 5: nine legal moves, no line.
    user_play("g5_u1", 1, 0, 0);
    ai_play("g5_a2", 2, 0, 0, 0);
    user_play("g5_u3", 3, 0, 0);
    ai_play("g5_a5", 5, 0, 0, 0);
    user_play("g5_u4", 4, 0, 0);
    ai_play("g5_a6", 6, 0, 0, 0);
    user_play("g5_u8", 8, 0, 0);
    ai_play("g5_a7", 7, 0, 0, 0);
    user_play("g5_u9_draw", 9, 0, 0);

    // Random games against the model.
    for (int g = 0; g < 6; g++) begin
      start = games_done;
      guard = 0;
      while (games_done == start && guard < 40) begin
        guard++;
        r = int'($urandom_range(0, 9));
        if (m_user) begin
          user_play("rnd_user", (r < 2) ? m_random_illegal() : m_random_empty(),
                    0, r == 9);
        end else begin
          ai_play("rnd_ai", (r < 3) ? m_random_illegal() : m_random_empty(),
                  int'($urandom_range(0, 2)), r == 0, r == 9);
        end
      end
      check("rnd_game_finished", (games_done != start) ? 1 : 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Turn scheduler for the tic-tac-toe design. Owns the 18-bit game board and alternates moves between the UART user front end (user plays O) and the computer move generator (FPGA plays X).
- Validates every move, detects win and draw, and sends the result strobe to the user front end.
- Waits for the front end to finish printing the result, then clears the board and starts the next game.

Parameters:
- USER_FIRST, 1, first game starts with the user (1) or the FPGA (0).
- ALTERNATE_FIRST, 1, when 1 the first mover toggles after every finished game.
- AI_TIMEOUT, 24'd1000000, clocks to wait for an AI move before falling back to a default move.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  asynchronous active-low reset
- o_board  out  18  board; square 1 = bits[17:16] ... square 9 = bits[1:0]; 00 empty, 01 O, 10 X
- o_needinput  out  1  request a user move (level)
- i_user_busy  in  1  user front end busy printing or receiving
- i_user_move  in  4  user square, valid with strobe
- i_user_move_stb  in  1  one-cycle user move strobe
- o_ai_req  out  1  one-cycle request for an FPGA move on current o_board
- i_ai_move  in  4  AI square, valid with strobe
- i_ai_move_stb  in  1  one-cycle AI move strobe
- o_result  out  2  1 = X (FPGA) wins, 2 = O (user) wins, 0 = none
- o_isdraw  out  1  game drawn
- o_result_stb  out  1  one-cycle strobe; o_result/o_isdraw valid
- o_user_turn  out  1  1 while the user is on move

Behaviour:
- Reset (async, i_rst_n=0):
  - o_board=0, o_needinput=0, o_ai_req=0, o_result=0, o_isdraw=0, o_result_stb=0.
  - o_user_turn=USER_FIRST; state=S_START. All outputs registered.
- S_START: wait until i_user_busy=0, so the instruction print finishes. Then go to S_USER if the user is on move, else S_AI_REQ.
- S_USER:
  - o_needinput=1 while in this state.
  - On i_user_move_stb, latch the move; o_needinput=0 from the next cycle; go to S_USER_CHK.
- S_USER_CHK:
  - Move valid iff 1..9 and the square is empty.
  - Valid: write 01 into the square, go to S_EVAL.
  - Invalid (0, 10..15, or occupied): board unchanged; wait for i_user_busy=0, then return to S_USER (re-prompt).
- S_AI_REQ: pulse o_ai_req for one cycle; clear the timeout counter; go to S_AI_WAIT.
- S_AI_WAIT:
  - On i_ai_move_stb, write 10 into the AI square if it is valid and empty.
  - Otherwise (invalid square, or counter reaching AI_TIMEOUT-1), write 10 into the lowest-numbered empty square.
  - Then go to S_EVAL.
- S_EVAL:
  - Evaluate 8 lines: 3 rows, 3 columns, 2 diagonals.
  - Three 10s in a line: o_result=1. Three 01s: o_result=2. Board full (no 00) with no win: o_isdraw=1.
  - Any of these: assert o_result_stb for exactly one cycle and go to S_RES_HI.
  - Otherwise toggle o_user_turn and go to S_USER or S_AI_REQ.
  - Move written to evaluation complete takes 1 cycle.
- S_RES_HI / S_RES_LO: wait for i_user_busy to go 1, then 0 (result printed).
- S_CLEAR:
  - o_board=0, o_result=0, o_isdraw=0.
  - If ALTERNATE_FIRST, set o_user_turn to the inverse of the previous game's first mover; otherwise USER_FIRST.
  - Go to S_START.
- Strobes outside their wait state (user stb outside S_USER, AI stb outside S_AI_WAIT) are ignored; board unchanged.
- Simultaneous user and AI strobes: only the strobe matching the current state is honoured.
- A win on the ninth move is reported as a win, never a draw.
- o_board changes only in S_USER_CHK, S_AI_WAIT and S_CLEAR; it is stable while o_needinput=1 or o_ai_req=1.
- Reset mid-game or mid-result: immediate return to reset values; no o_result_stb is issued.

Test Plan:
- USER_FIRST=1, user plays 1,2,3 (stb, i_user_move=4'h1/2/3); AI plays 5,9 → o_board=18'b01_01_01_00_10_00_00_00_10, o_result=2, one-cycle o_result_stb.
- User moves 5 while square 5 = X; then 4'hA → board unchanged both times, o_needinput re-asserted after i_user_busy=0, no o_ai_req.
- AI plays 3,5,7 against user 1,2,4 → o_result=1 on the AI's third move; next game starts with the AI (o_ai_req first) since ALTERNATE_FIRST=1.
- Nine legal alternating moves with no line (user 1,3,4,8,9; AI 2,5,6,7) → o_isdraw=1, o_result=0; after busy 1→0 the board reads 0.
- AI never strobes, AI_TIMEOUT=16 → 16 cycles after o_ai_req, X is written to the lowest empty square; an AI strobe for occupied square 1 likewise falls back.
- Assert i_rst_n=0 while in S_AI_WAIT with 4 moves placed → all outputs zero asynchronously; after release the sequence restarts at S_START.
